pwm_multi: RTL
==============

# pwm_multi

Multi-channel, parametrised PWM generator sharing one period counter across `CH` outputs. Each channel has its own duty register. Period and duty values are written through a simple register-write port into shadow registers. Shadow values transfer to the active set only at a period boundary, so outputs never glitch mid-period. It replaces the fixed single-channel, fixed 10/3 PWM in motor/LED drive paths.

## Interface
- `CH`, 4, number of PWM channels (1..16)
- `CNT_W`, 16, width of counter, period and duty values
- `PERIOD_RST`, 10, period loaded at reset (clocks per period)
- `DUTY_RST`, 3, duty loaded into every channel at reset (high clocks per period)
- `clk`  in  1  system clock, rising-edge
- `n_reset`  in  1  asynchronous, active-low reset
- `en`  in  1  global enable; 0 holds counter at 0 and forces outputs low
- `wr_en`  in  1  single-cycle register write strobe
- `wr_addr`  in  $clog2(CH+2)  0 = period, 1..CH = duty of channel addr-1, CH+1 = mode
- `wr_data`  in  CNT_W  write data
- `pwm_out`  out  CH  registered PWM outputs, bit i = channel i
- `sync`  out  1  one-cycle pulse, first cycle of each period

## Operation
- Reset values:
  - `pwm_out`=0, `sync`=0, counter=0.
  - Shadow and active period = `PERIOD_RST`.
  - Shadow and active duties = `DUTY_RST`.
  - Mode = 0.
- Writes with `wr_en`=1 update the addressed shadow register at the clock edge.
- Writes to unused addresses are ignored. Last write before a boundary wins.
- Edge-aligned mode (mode 0):
  - Counter runs 0..P-1, then wraps to 0. P = active period.
  - P=0 is treated as P=1: the counter stays at 0.
- Boundary: the cycle in which the counter is at its last value (P-1 in mode 0).
  - On the boundary edge, all shadow registers (period, duties, mode) copy to the active set.
  - The new values govern the counter from its next value 0.
- Compare: channel i next output = `en` AND (cnt < duty_act[i]), unsigned CNT_W compare.
  - duty=0 gives constant low.
  - duty≥P gives constant high (100%).
- `sync` next value = `en` AND (cnt == 0).
- With `en`=0:
  - Counter is held at 0.
  - Shadows copy to active every cycle.
  - Outputs are forced to 0.
- Reset mid-operation: immediate return to reset values. Written shadow values are lost.

## Timing
- `pwm_out` and `sync` are registered: they lag the counter by one clock.
- Duty=D, period=P: `pwm_out[i]` is high exactly D consecutive clocks per P-clock period. The rising edge is coincident with `sync`.
- A write at edge t takes effect at the first period boundary after t. Worst-case latency is P clocks plus 1 output register.
- A write landing on the boundary edge itself is not transferred until the following boundary.
- `en` 0→1 at edge t:
  - Counter = 0 during cycle t.
  - First `sync` and `pwm_out` high appear after edge t+1.
- `en` 1→0: outputs are low after the next edge. The counter is 0 from the next edge.

## Configuration
- `PWM_CENTER_ALIGN_EN` defined:
  - Address CH+1 writes mode = `wr_data[0]`, buffered through the shadow like the other registers.
  - Mode 1 is center-aligned. The counter counts up 0..P-1, then down P-1..0, giving a 2P-clock period.
  - The boundary is the cycle with the counter at 0 while counting down.
  - The compare is unchanged, so the high pulse is centred: 2D clocks high per 2P-clock period.
  - `sync` pulses only at the start of the up phase.
- Undefined:
  - Address CH+1 is ignored and mode is constant 0.
  - No direction state is synthesised.
  - Port list is identical in both builds.

## Structure
- Package `pwm_multi_pkg`:
  - Address constants `ADDR_PERIOD`=0, `ADDR_DUTY_BASE`=1.
  - Mode enum {`PWM_EDGE`, `PWM_CENTER`}.
  - Mode address offset (CH+1) as a function of CH.
- Sub-module `pwm_channel`, instantiated CH times via generate:
  - Holds its shadow and active duty.
  - Receives the write strobe and the boundary pulse.
  - Produces the registered compare output.
- The top holds the counter, direction flag, period/mode registers, boundary detect and `sync`.

## Test plan
- Reset with defaults, `en`=1, CH=4 → every `pwm_out` bit high 3 clocks, low 7, repeating. `sync` every 10 clocks, aligned with the rising edges.
- Write duty ch2=7 mid-period at counter 4 → current period unchanged (3 high). The next period shows ch2 7 high / 3 low; other channels unchanged.
- Write period=5 and ch0 duty=0, ch1 duty=5, ch3 duty=9 → after the boundary: ch0 constant low, ch1 and ch3 constant high, `sync` every 5 clocks.
- Drop `en` mid-high-phase, re-raise after 20 clocks → outputs low one clock after drop. First `sync` and high cycle appear 2 edges after re-raise.
- Assert `n_reset` mid-period after a pending shadow write → outputs 0 immediately. After release, 10/3 waveform resumes; the pending write is discarded.
- With `PWM_CENTER_ALIGN_EN`, mode=1, period=10, duty=3 → 20-clock period, 6 clocks high centred on counter 0 (3 down + 3 up). `sync` every 20 clocks. Without the macro, the same write leaves the 10-clock edge waveform.

Source files
------------

// File: rtl/pwm_multi_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// Register map: period at ADDR_PERIOD, channel duties from ADDR_DUTY_BASE,
// mode register directly after the last duty register.
package pwm_multi_pkg;

   localparam int unsigned ADDR_PERIOD    = 32'd0;
   localparam int unsigned ADDR_DUTY_BASE = 32'd1;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   // Address of the mode register for a build with ch channels.
   function automatic int unsigned mode_addr(input int unsigned ch);
      return ch + 32'd1;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair and the registered compare output.
// The shadow takes writes at any time; the active duty only changes on load,
// which the top raises at a period boundary or while the generator is disabled.
module pwm_channel
   import pwm_multi_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DUTY_RST = 3
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             en,
   input  logic             wr_sel,
   input  logic [CNT_W-1:0] wr_data,
   input  logic             load,
   input  logic [CNT_W-1:0] cnt,
   output logic             pwm
);

   localparam logic [CNT_W-1:0] DUTY_INIT = CNT_W'(DUTY_RST);

   logic [CNT_W-1:0] duty_sh;
   logic [CNT_W-1:0] duty_act;
   logic             pwm_nxt;

   // Compare: high while the shared counter is below the active duty.
   always_comb begin
      pwm_nxt = 1'b0;
      if (en && (cnt < duty_act)) begin
         pwm_nxt = 1'b1;
      end else begin
         pwm_nxt = 1'b0;
      end
   end

   // Shadow duty takes writes; active duty follows the shadow on load.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         duty_sh  <= DUTY_INIT;
         duty_act <= DUTY_INIT;
      end else begin
         if (wr_sel) begin
            duty_sh <= wr_data;
         end
         if (load) begin
            duty_act <= duty_sh;
         end
      end
   end

   // Output register keeps the pin glitch-free.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         pwm <= 1'b0;
      end else begin
         pwm <= pwm_nxt;
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with one shared period counter.
// Optional macro PWM_CENTER_ALIGN_EN adds a center-aligned (up/down) mode
// selected through the mode register; without it the mode register address
// is ignored and only edge-aligned counting exists.
module pwm_multi
   import pwm_multi_pkg::*;
#(
   parameter int unsigned CH         = 4,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned PERIOD_RST = 10,
   parameter int unsigned DUTY_RST   = 3
) (
   input  logic                      clk,
   input  logic                      n_reset,
   input  logic                      en,
   input  logic                      wr_en,
   input  logic [$clog2(CH+2)-1:0]   wr_addr,
   input  logic [CNT_W-1:0]          wr_data,
   output logic [CH-1:0]             pwm_out,
   output logic                      sync
);

   localparam int unsigned      AW          = $clog2(CH + 2);
   localparam logic [CNT_W-1:0] ZERO        = CNT_W'(32'd0);
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] period_sh;
   logic [CNT_W-1:0] period_act;
   logic [CNT_W-1:0] period_eff;
   logic [CNT_W-1:0] last;
   logic             boundary;
   logic             load;
   logic             sync_nxt;

`ifdef PWM_CENTER_ALIGN_EN
   pwm_mode_e        mode_sh;
   pwm_mode_e        mode_act;
   logic             dir_down;
   logic             dir_down_nxt;
`endif

   // A zero period behaves as a one-clock period; last is the top count.
   always_comb begin
      period_eff = ONE;
      if (period_act == ZERO) begin
         period_eff = ONE;
      end else begin
         period_eff = period_act;
      end
      last = period_eff - ONE;
   end

   // Next counter value, boundary detection and sync request.
   always_comb begin
      cnt_nxt  = cnt;
      boundary = 1'b0;
      sync_nxt = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_down_nxt = dir_down;
`endif
      if (!en) begin
         cnt_nxt = ZERO;
`ifdef PWM_CENTER_ALIGN_EN
         dir_down_nxt = 1'b0;
`endif
      end else begin
`ifdef PWM_CENTER_ALIGN_EN
         // Zero is visited twice in center mode; only the up phase syncs.
         sync_nxt = (cnt == ZERO) && !dir_down;
         case (mode_act)
            PWM_CENTER: begin
               if (!dir_down) begin
                  if (cnt == last) begin
                     dir_down_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt + ONE;
                  end
               end else begin
                  if (cnt == ZERO) begin
                     boundary     = 1'b1;
                     dir_down_nxt = 1'b0;
                  end else begin
                     cnt_nxt = cnt - ONE;
                  end
               end
            end
            default: begin
               dir_down_nxt = 1'b0;
               if (cnt == last) begin
                  boundary = 1'b1;
                  cnt_nxt  = ZERO;
               end else begin
                  cnt_nxt = cnt + ONE;
               end
            end
         endcase
`else
         sync_nxt = (cnt == ZERO);
         if (cnt == last) begin
            boundary = 1'b1;
            cnt_nxt  = ZERO;
         end else begin
            cnt_nxt = cnt + ONE;
         end
`endif
      end
   end

   // While disabled the active set tracks the shadows every cycle.
   assign load = !en || boundary;

   // Shared counter, direction flag and registered sync pulse.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt  <= ZERO;
         sync <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_down <= 1'b0;
`endif
      end else begin
         cnt  <= cnt_nxt;
         sync <= sync_nxt;
`ifdef PWM_CENTER_ALIGN_EN
         dir_down <= dir_down_nxt;
`endif
      end
   end

   // Period and mode shadow registers, transferred to active on load.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         period_sh  <= PERIOD_INIT;
         period_act <= PERIOD_INIT;
`ifdef PWM_CENTER_ALIGN_EN
         mode_sh    <= PWM_EDGE;
         mode_act   <= PWM_EDGE;
`endif
      end else begin
         if (wr_en && (wr_addr == AW'(ADDR_PERIOD))) begin
            period_sh <= wr_data;
         end
         if (load) begin
            period_act <= period_sh;
         end
`ifdef PWM_CENTER_ALIGN_EN
         if (wr_en && (wr_addr == AW'(mode_addr(CH)))) begin
            mode_sh <= pwm_mode_e'(wr_data[0]);
         end
         if (load) begin
            mode_act <= mode_sh;
         end
`endif
      end
   end

   // One compare channel per output bit.
   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic wr_sel;
      assign wr_sel = wr_en && (wr_addr == AW'(ADDR_DUTY_BASE + i));

      pwm_channel #(
         .CNT_W    (CNT_W),
         .DUTY_RST (DUTY_RST)
      ) u_channel (
         .clk     (clk),
         .n_reset (n_reset),
         .en      (en),
         .wr_sel  (wr_sel),
         .wr_data (wr_data),
         .load    (load),
         .cnt     (cnt),
         .pwm     (pwm_out[i])
      );
   end

endmodule
